// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmitter. Issues one byte per frame over a
// request/finish handshake and holds tx_data stable for the whole frame.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              drop,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              tx_data_request,
  output logic [7:0]        tx_data,
  input  logic              tx_active,
  input  logic              tx_finish
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_en, pop;

  // Flags come from the registered count only, so a same-edge pop never
  // opens room for a write while full.
  assign full     = (count == COUNT_FULL);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign wr_en    = wr_valid && !full;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_active) begin
          pop        = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_finish)      state_next = IDLE;
        else if (tx_active) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      tx_data         <= 8'h00;
      tx_data_request <= 1'b0;
      drop            <= 1'b0;
    end else begin
      state           <= state_next;
      tx_data_request <= pop;
      drop            <= wr_valid && full;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count define which entries are valid, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a queue-based byte model plus a
// behavioural transmitter, with directed scenarios and a randomized run.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              wr_ready, drop, empty, full, tx_data_request;
  logic [ADDR_W:0]   count;
  logic [7:0]        tx_data;
  logic              tx_active;
  logic              tx_finish = 1'b0;
  logic              model_active = 1'b0;
  logic              hold_busy = 1'b0;

  assign tx_active = model_active | hold_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int len_min = 40;
  int len_max = 40;
  int acc_total = 0;
  bit busy_frame = 1'b0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] mon_exp;
  bit mon_acc;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int req_cyc[$];
  int fin_cyc[$];

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .drop            (drop),
    .count           (count),
    .empty           (empty),
    .full            (full),
    .tx_data_request (tx_data_request),
    .tx_data         (tx_data),
    .tx_active       (tx_active),
    .tx_finish       (tx_finish)
  );

  always #5 clk = ~clk;

  // Transmitter: busy from the cycle after the request, finish pulse at frame end.
  initial begin : transmitter
    int len;
    forever begin
      @(negedge clk);
      if (tx_data_request) begin
        len = $urandom_range(len_max, len_min);
        @(negedge clk);
        model_active = 1'b1;
        repeat (len) @(negedge clk);
        tx_finish = 1'b1;
        @(negedge clk);
        tx_finish    = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  // Scoreboard: every edge, the stored bytes are exactly the accepted bytes not yet issued.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        busy_frame = 1'b0;
        last_tx    = 8'h00;
        continue;
      end
      mon_acc = wr_valid && (exp_q.size() < DEPTH);
      checks++;
      if (tx_data_request) begin
        if (tx_active) begin
          errors++;
          $display("FAIL req_gate: request issued while tx_active=1");
        end
        if (busy_frame) begin
          errors++;
          $display("FAIL req_in_frame: request at cycle %0d before previous frame finished", cyc);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL req_empty: request with tx_data=%02h but no byte was stored", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp) begin
            errors++;
            $display("FAIL tx_data_order: got %02h, required %02h", tx_data, mon_exp);
          end
        end
        obs_q.push_back(tx_data);
        req_cyc.push_back(cyc);
      end else if (tx_data !== last_tx) begin
        errors++;
        $display("FAIL tx_data_hold: changed %02h -> %02h without a request", last_tx, tx_data);
      end
      last_tx = tx_data;
      if (tx_finish) begin
        busy_frame = 1'b0;
        fin_cyc.push_back(cyc);
      end
      if (tx_data_request) busy_frame = 1'b1;
      if (mon_acc) begin
        exp_q.push_back(wr_data);
        acc_total++;
      end
      checks++;
      if (count !== (ADDR_W + 1)'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
          full !== (exp_q.size() == DEPTH) || wr_ready !== (exp_q.size() != DEPTH)) begin
        errors++;
        $display("FAIL flags: count=%0d empty=%b full=%b wr_ready=%b, required count=%0d",
                 count, empty, full, wr_ready, exp_q.size());
      end
      checks++;
      if (drop !== (wr_valid && !mon_acc)) begin
        errors++;
        $display("FAIL drop: got %b, required %b", drop, wr_valid && !mon_acc);
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "time limit");
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
  endtask

  task automatic push_when_room(input logic [7:0] b);
    @(negedge clk);
    while (full) begin
      wr_valid = 1'b0;
      @(negedge clk);
    end
    wr_valid = 1'b1;
    wr_data  = b;
  endtask

  task automatic release_wr();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_frame || tx_active) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still queued after 5000 cycles, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_data_request !== 1'b0 || tx_data !== 8'h00 || count !== '0 || empty !== 1'b1 ||
        full !== 1'b0 || wr_ready !== 1'b1 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req=%b data=%02h count=%0d empty=%b full=%b ready=%b drop=%b",
               tx_data_request, tx_data, count, empty, full, wr_ready, drop);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (count !== '0 || tx_data_request !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: count=%0d req=%b, required 0 0", count, tx_data_request);
    end
  endtask

  task automatic test_single();
    len_min = 3; len_max = 3;
    push(8'hA5);
    release_wr();
    checks++;
    if (count !== 5'd1 || tx_data_request !== 1'b0) begin
      errors++;
      $display("FAIL single_e0: count=%0d req=%b, required 1 0", count, tx_data_request);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_data_request !== 1'b1 || tx_data !== 8'hA5 || count !== 5'd0) begin
      errors++;
      $display("FAIL single_e1: req=%b data=%02h count=%0d, required 1 a5 0",
               tx_data_request, tx_data, count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_data_request !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: request still %b one cycle later, required 0", tx_data_request);
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    len_min = 40; len_max = 40;
    obs_q.delete(); req_cyc.delete(); fin_cyc.delete();
    push(8'h01); push(8'h02); push(8'h03);
    release_wr();
    wait_drain("b2b");
    checks++;
    if (obs_q.size() != 3 || obs_q[0] !== 8'h01 || obs_q[1] !== 8'h02 || obs_q[2] !== 8'h03) begin
      errors++;
      $display("FAIL b2b_sequence: %0d requests, required 3 in order 01 02 03", obs_q.size());
    end else begin
      checks++;
      if (fin_cyc.size() != 3 || req_cyc[1] != fin_cyc[0] + 1 || req_cyc[2] != fin_cyc[1] + 1) begin
        errors++;
        $display("FAIL b2b_turnaround: req cycles %0d %0d after finish %0d %0d, required finish+1",
                 req_cyc[1], req_cyc[2], fin_cyc[0], fin_cyc[1]);
      end
    end
  endtask

  task automatic test_full_and_drop();
    logic [7:0] sent [DEPTH + 2];
    int drops = 0;
    len_min = 2; len_max = 6;
    obs_q.delete();
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      sent[i] = 8'($urandom);
      push(sent[i]);
      @(posedge clk);
      #1;
      if (drop) drops++;
      if (i == DEPTH - 1) begin
        checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_at_depth: full=%b wr_ready=%b, required 1 0", full, wr_ready);
        end
      end
    end
    checks++;
    if (drops != 2 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_drops: drops=%0d count=%0d, required 2 16", drops, count);
    end
    @(negedge clk);
    hold_busy = 1'b0;
    wr_data   = 8'hEE;
    @(posedge clk);
    #1;
    checks++;
    if (drop !== 1'b1 || count !== 5'd15 || tx_data_request !== 1'b1 || tx_data !== sent[0]) begin
      errors++;
      $display("FAIL full_pop_write: drop=%b count=%0d req=%b data=%02h, required 1 15 1 %02h",
               drop, count, tx_data_request, tx_data, sent[0]);
    end
    release_wr();
    wait_drain("full");
    checks++;
    if (obs_q.size() != DEPTH) begin
      errors++;
      $display("FAIL full_drain_count: %0d bytes issued, required %0d", obs_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (obs_q[i] !== sent[i]) begin
          errors++;
          $display("FAIL full_drain_order: byte %0d got %02h, required %02h", i, obs_q[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    len_min = 1; len_max = 4;
    obs_q.delete();
    for (int i = 0; i < 40; i++) begin
      push_when_room(8'(i));
      if ($urandom_range(0, 2) == 0) release_wr();
    end
    release_wr();
    wait_drain("wrap");
    checks++;
    if (obs_q.size() != 40 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_total: %0d bytes issued empty=%b, required 40 1", obs_q.size(), empty);
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (obs_q[i] !== 8'(i)) begin
          errors++;
          $display("FAIL wrap_order: byte %0d got %02h, required %02h", i, obs_q[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    int acc0;
    len_min = 1; len_max = 6;
    obs_q.delete();
    acc0 = acc_total;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 99) < 45);
      wr_data  = 8'($urandom);
    end
    release_wr();
    wait_drain("random");
    checks++;
    if (obs_q.size() != acc_total - acc0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL random_total: %0d bytes issued empty=%b, required %0d 1",
               obs_q.size(), empty, acc_total - acc0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    len_min = 40; len_max = 40;
    obs_q.delete();
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    release_wr();
    while (obs_q.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    hold_busy = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL midframe_queued: count=%0d, required 5", count);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_data_request !== 1'b0 || tx_data !== 8'h00 || count !== '0 || empty !== 1'b1 ||
        full !== 1'b0 || wr_ready !== 1'b1 || drop !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: req=%b data=%02h count=%0d empty=%b full=%b ready=%b drop=%b",
               tx_data_request, tx_data, count, empty, full, wr_ready, drop);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    push(8'h5A);
    release_wr();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx_data_request !== 1'b0) begin
        errors++;
        $display("FAIL midframe_gate: request at cycle %0d while transmitter busy", i);
      end
    end
    @(negedge clk);
    hold_busy = 1'b0;
    n = 0;
    while (obs_q.size() == 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL midframe_resume: %0d requests after release, required one with 5a", obs_q.size());
    end
    wait_drain("midframe");
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_full_and_drop();
    test_wrap();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
